// File: rtl/sr_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sr_reg_pkg
// Purpose : Shared types and next-state helper for the sr_reg_bank set/reset
//           storage channels.
// Contents:
//   sr_mode_e - conflict resolution mode applied when S=R=1
//               (HOLD, SET_DOM, RST_DOM, TOGGLE)
//   sr_next   - next value of one channel from its s, r, current q and mode
// Revision: 1.0 - initial release
// ============================================================================
package sr_reg_pkg;

   typedef enum logic [1:0] {
      SR_HOLD    = 2'b00,
      SR_SET_DOM = 2'b01,
      SR_RST_DOM = 2'b10,
      SR_TOGGLE  = 2'b11
   } sr_mode_e;

   // Next stored value for a single channel. The S=R=1 case is resolved by
   // mode, so a channel always has a defined next state.
   function automatic logic sr_next(
      input logic     s,
      input logic     r,
      input logic     q,
      input sr_mode_e mode
   );
      logic nq;
      case ({s, r})
         2'b00:   nq = q;
         2'b10:   nq = 1'b1;
         2'b01:   nq = 1'b0;
         default: begin
            case (mode)
               SR_HOLD:    nq = q;
               SR_SET_DOM: nq = 1'b1;
               SR_RST_DOM: nq = 1'b0;
               SR_TOGGLE:  nq = ~q;
               default:    nq = q;
            endcase
         end
      endcase
      return nq;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_sync2.sv
`default_nettype none
// ============================================================================
// Module  : sr_sync2
// Purpose : W-bit two-flop synchronizer, both stages reset to 0.
// Ports   :
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset
//   d     in  W  asynchronous input bits
//   q     out W  synchronized bits (two clk edges after d)
// Revision: 1.0 - initial release
// ============================================================================
module sr_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/sr_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : sr_reg_bank
// Purpose : Bank of N independent clocked set/reset storage channels with
//           mode-selectable S=R=1 resolution, registered rise/fall pulses,
//           sticky per-channel conflict flags and a shared saturating
//           conflict counter.
// Config  : define SR_REG_BANK_SYNC_EN to pass s, r and flag_clr through a
//           2-flop synchronizer (adds 2 cycles of latency to those inputs;
//           mode and cnt_clr are used directly).
// Ports   :
//   clk           in  1      rising-edge clock
//   rst_n         in  1      asynchronous active-low reset
//   s             in  N      per-channel set request
//   r             in  N      per-channel reset request
//   mode          in  2      S=R=1 resolution (00 HOLD,01 SET,10 RST,11 TGL)
//   flag_clr      in  N      write-1-to-clear for conflict_flag
//   cnt_clr       in  1      synchronous clear of conflict_cnt
//   q             out N      stored channel values
//   qn            out N      ~q
//   q_rise        out N      one-cycle pulse on a 0->1 change of q
//   q_fall        out N      one-cycle pulse on a 1->0 change of q
//   conflict_flag out N      sticky S=R=1 indicator per channel
//   conflict_cnt  out CNT_W  saturating count of cycles with any conflict
// Revision: 1.0 - initial release
// ============================================================================
module sr_reg_bank
   import sr_reg_pkg::*;
#(
   parameter int           N       = 8,
   parameter logic [N-1:0] RST_VAL = {N{1'b0}},
   parameter int           CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     s,
   input  logic [N-1:0]     r,
   input  logic [1:0]       mode,
   input  logic [N-1:0]     flag_clr,
   input  logic             cnt_clr,
   output logic [N-1:0]     q,
   output logic [N-1:0]     qn,
   output logic [N-1:0]     q_rise,
   output logic [N-1:0]     q_fall,
   output logic [N-1:0]     conflict_flag,
   output logic [CNT_W-1:0] conflict_cnt
);

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------
   logic [N-1:0] s_use;
   logic [N-1:0] r_use;
   logic [N-1:0] clr_use;

`ifdef SR_REG_BANK_SYNC_EN
   logic [3*N-1:0] sync_out;

   sr_sync2 #(
      .W (3*N)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({s, r, flag_clr}),
      .q     (sync_out)
   );

   assign s_use   = sync_out[3*N-1:2*N];
   assign r_use   = sync_out[2*N-1:N];
   assign clr_use = sync_out[N-1:0];
`else
   assign s_use   = s;
   assign r_use   = r;
   assign clr_use = flag_clr;
`endif

   sr_mode_e mode_e;
   assign mode_e = sr_mode_e'(mode);

   // ---------------------------------------------------------------------
   // Channel array
   // ---------------------------------------------------------------------
   logic [N-1:0] q_q,    q_d;
   logic [N-1:0] rise_q, rise_d;
   logic [N-1:0] fall_q, fall_d;
   logic [N-1:0] flag_q, flag_d;
   logic [N-1:0] conflict;

   for (genvar i = 0; i < N; i++) begin : g_chan
      assign conflict[i] = s_use[i] & r_use[i];
      assign q_d[i]      = sr_next(s_use[i], r_use[i], q_q[i], mode_e);
      // Pulses are derived from the next value so they register on the same
      // edge as q and line up with the changed q.
      assign rise_d[i]   = q_d[i] & ~q_q[i];
      assign fall_d[i]   = ~q_d[i] & q_q[i];
      // A new conflict takes precedence over a clear on the same edge.
      assign flag_d[i]   = conflict[i] | (flag_q[i] & ~clr_use[i]);
   end

   // ---------------------------------------------------------------------
   // Shared conflict counter
   // ---------------------------------------------------------------------
   logic             any_conflict;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign any_conflict = |conflict;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         // Clear still counts a conflict seen on the same edge.
         cnt_d = any_conflict ? CNT_W'(1) : '0;
      end else if (any_conflict && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= RST_VAL;
         rise_q <= '0;
         fall_q <= '0;
         flag_q <= '0;
         cnt_q  <= '0;
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q             = q_q;
   assign qn            = ~q_q;
   assign q_rise        = rise_q;
   assign q_fall        = fall_q;
   assign conflict_flag = flag_q;
   assign conflict_cnt  = cnt_q;

endmodule
`default_nettype wire
